// File: rtl/pkg_value_streamer_pkg.sv
// Shared constants, FSM state type and parity helper for the per-channel value streamer.
package pkg_value_streamer_pkg;

  localparam int STREAMER_Z     = 1;
  localparam int STREAMER_INIT  = STREAMER_Z;
  localparam int STREAMER_WIDTH = STREAMER_Z;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  function automatic logic even_parity(input logic [63:0] value);
    even_parity = ^value;
  endfunction

endpackage

// File: rtl/pkg_value_bank.sv
// Channel register bank: one WIDTH-bit register per channel, indexed write port and a
// combinational read that already reflects a same-cycle write to the read channel.
module pkg_value_bank
  import pkg_value_streamer_pkg::*;
#(
  parameter int          WIDTH    = STREAMER_WIDTH,
  parameter int          N_CH     = 4,
  parameter logic [63:0] INIT_VAL = 64'(STREAMER_INIT),
  parameter int          CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [N_CH];
  logic [WIDTH-1:0] mem_d [N_CH];

  // Next bank contents; an index with no matching channel leaves every entry untouched.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mem_d[i] = (wr_en && (wr_ch == CH_W'(i))) ? wr_data : mem_q[i];
    end
  end

  // Reading the next-state array gives write-through forwarding for free.
  always_comb begin
    rd_data = mem_d[0];
    for (int i = 1; i < N_CH; i++) begin
      rd_data = (rd_ch == CH_W'(i)) ? mem_d[i] : rd_data;
    end
  end

  // Bank register array with synchronous reset to the init constant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        mem_q[i] <= INIT_VAL[WIDTH-1:0];
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/pkg_value_streamer.sv
// Streams every channel register in index order over valid/ready with a last flag.
// Optional registered even-parity output enabled by PKG_VALUE_STREAMER_PARITY_EN.
module pkg_value_streamer
  import pkg_value_streamer_pkg::*;
#(
  parameter int          WIDTH    = STREAMER_WIDTH,
  parameter int          N_CH     = 4,
  parameter logic [63:0] INIT_VAL = 64'(STREAMER_INIT),
  parameter int          CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
`ifdef PKG_VALUE_STREAMER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  stream_state_e    state_q, state_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d, nxt_ch, rd_ch;
  logic [WIDTH-1:0] out_data_q, out_data_d, rd_data;
  logic             busy_q, busy_d, out_valid_q, out_valid_d, out_last_q, out_last_d;

  pkg_value_bank #(
    .WIDTH   (WIDTH),
    .N_CH    (N_CH),
    .INIT_VAL(INIT_VAL),
    .CH_W    (CH_W)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
    .rd_ch  (rd_ch),
    .rd_data(rd_data)
  );

  // Channel that would be loaded at the next edge: ch0 on a start, else the successor.
  always_comb begin
    nxt_ch = out_ch_q + CH_W'(1);
    rd_ch  = (state_q == STREAM) ? nxt_ch : CH_W'(0);
  end

  // Stream FSM next-state and beat register updates.
  always_comb begin
    state_d     = state_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          out_ch_d    = CH_W'(0);
          out_data_d  = rd_data;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (LAST_CH == CH_W'(0));
        end else begin
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      STREAM: begin
        if (out_ready && out_last_q) begin
          state_d     = IDLE;
          out_ch_d    = CH_W'(0);
          out_data_d  = '0;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (out_ready) begin
          out_ch_d    = nxt_ch;
          out_data_d  = rd_data;
          out_last_d  = (nxt_ch == LAST_CH);
        end else begin
          state_d     = STREAM;
        end
      end
      default: begin
        state_d     = IDLE;
        out_ch_d    = CH_W'(0);
        out_data_d  = '0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // FSM state and beat output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_ch_q    <= CH_W'(0);
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef PKG_VALUE_STREAMER_PARITY_EN
  logic out_parity_q, out_parity_d;

  // Parity follows out_data_d, so it is held whenever the beat is held.
  always_comb begin
    out_parity_d = even_parity(64'(out_data_d));
  end

  // Parity register loaded alongside the beat data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign out_parity = out_parity_q;
`endif

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pkg_value_streamer.sv
// Self-checking bench: a spec-level channel/stream model checked every cycle, directed
// literal passes, randomized traffic, plus default-parameter and N_CH=1 instances.
module tb_pkg_value_streamer;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  // main DUT: WIDTH=8, N_CH=5 (non power of two so wr_ch 5..7 is out of range)
  logic       wr_en = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [2:0] wr_ch = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, out_valid, out_last;
  logic [2:0] out_ch;
  logic [7:0] out_data;
  // default-parameter DUT: WIDTH=1, N_CH=4
  logic       b_start = 1'b0, b_ready = 1'b1, b_wr_en = 1'b0, b_busy, b_valid, b_last;
  logic [1:0] b_wr_ch = 2'd0, b_ch;
  logic [0:0] b_wr_data = 1'b0, b_data;
  // single-channel DUT: WIDTH=8, N_CH=1, INIT_VAL=0x5A
  logic       o_start = 1'b0, o_ready = 1'b0, o_wr_en = 1'b0, o_busy, o_valid, o_last;
  logic [0:0] o_wr_ch = 1'b0, o_ch;
  logic [7:0] o_wr_data = 8'h00, o_data;
`ifdef PKG_VALUE_STREAMER_PARITY_EN
  logic out_parity, b_parity, o_parity;
`endif

  always #5 clk = ~clk;

  pkg_value_streamer #(.WIDTH(8), .N_CH(N), .INIT_VAL(64'h01)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_last(out_last)
`ifdef PKG_VALUE_STREAMER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  pkg_value_streamer dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_data(b_wr_data),
    .start(b_start), .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready),
    .out_ch(b_ch), .out_data(b_data), .out_last(b_last)
`ifdef PKG_VALUE_STREAMER_PARITY_EN
    , .out_parity(b_parity)
`endif
  );

  pkg_value_streamer #(.WIDTH(8), .N_CH(1), .INIT_VAL(64'h5A)) dut_one (
    .clk(clk), .rst_n(rst_n), .wr_en(o_wr_en), .wr_ch(o_wr_ch), .wr_data(o_wr_data),
    .start(o_start), .busy(o_busy), .out_valid(o_valid), .out_ready(o_ready),
    .out_ch(o_ch), .out_data(o_data), .out_last(o_last)
`ifdef PKG_VALUE_STREAMER_PARITY_EN
    , .out_parity(o_parity)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_chan [N];
  logic       m_active = 1'b0;
  logic       m_started = 1'b0;
  int         m_idx = 0;
  logic [7:0] m_data = 8'h00;

  // value channel k holds once this edge's write (if any) has landed
  function automatic logic [7:0] chan_now(input int k);
    if (wr_en && int'(wr_ch) == k) return wr_data;
    return m_chan[k];
  endfunction

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_chan[i] <= 8'h01;
      m_active <= 1'b0;
    end else begin
      if (wr_en && int'(wr_ch) < N) m_chan[wr_ch] <= wr_data;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_idx    <= 0;
          m_data   <= chan_now(0);
        end
      end else if (out_ready) begin
        if (m_idx == N - 1) begin
          m_active <= 1'b0;
        end else begin
          m_idx  <= m_idx + 1;
          m_data <= chan_now(m_idx + 1);
        end
      end
    end
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    if (m_started) begin
      chk("valid", {63'd0, out_valid}, {63'd0, m_active});
      chk("busy", {63'd0, busy}, {63'd0, m_active});
      if (m_active) begin
        chk("ch", 64'(out_ch), 64'(m_idx));
        chk("data", 64'(out_data), 64'(m_data));
        chk("last", {63'd0, out_last}, {63'd0, (m_idx == N - 1)});
`ifdef PKG_VALUE_STREAMER_PARITY_EN
        chk("parity", {63'd0, out_parity}, {63'd0, ^m_data});
`endif
      end
    end
  end

  // beat collector for the literal pass checks
  logic [7:0] beats [$];
  logic       collect = 1'b0;
  always @(negedge clk) begin
    if (collect && out_valid && out_ready) beats.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, {63'd0, (n >= 40)}, 64'd0);
  endtask

  task automatic wait_ch(input string nm, input logic [2:0] ch);
    int n = 0;
    while (!(out_valid && out_ch == ch) && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, {63'd0, (n >= 40)}, 64'd0);
  endtask

  task automatic begin_pass();
    beats.delete();
    collect = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // expected beat i sits at exp[8*(4-i) +: 8]
  task automatic expect_pass(input string nm, input logic [39:0] exp);
    collect = 1'b0;
    chk({nm, "_count"}, 64'(beats.size()), 64'd5);
    for (int i = 0; i < N && i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), 64'(beats[i]), 64'(exp[8*(4-i) +: 8]));
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    chk("rst_one_valid", {63'd0, o_valid}, 64'd0);
`ifdef PKG_VALUE_STREAMER_PARITY_EN
    chk("rst_parity", {63'd0, out_parity}, 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // defaults: WIDTH=1, N_CH=4, every beat 1, last on ch3 only
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_valid%0d", i), {63'd0, b_valid}, 64'd1);
      chk($sformatf("b_ch%0d", i), 64'(b_ch), 64'(i));
      chk($sformatf("b_data%0d", i), 64'(b_data), 64'd1);
      chk($sformatf("b_last%0d", i), {63'd0, b_last}, {63'd0, (i == 3)});
      tick();
    end
    chk("b_busy_end", {63'd0, b_busy}, 64'd0);
    chk("b_valid_end", {63'd0, b_valid}, 64'd0);

    // N_CH=1: a single beat that is also the last, held until accepted
    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    tick();
    chk("one_valid", {63'd0, o_valid}, 64'd1);
    chk("one_ch", 64'(o_ch), 64'd0);
    chk("one_last", {63'd0, o_last}, 64'd1);
    chk("one_data", 64'(o_data), 64'h5A);
    o_ready = 1'b1;
    tick();
    chk("one_valid_end", {63'd0, o_valid}, 64'd0);

    begin_pass();
    wait_idle("p_init");
    expect_pass("p_init", 40'h01_01_01_01_01);

    wr_en = 1'b1; wr_ch = 3'd2; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    begin_pass();
    wait_idle("p_a5");
    expect_pass("p_a5", 40'h01_01_A5_01_01);

    // stall on ch1 while ch1 is rewritten: held beat keeps the old value
    begin_pass();
    wait_ch("stall", 3'd1);
    out_ready = 1'b0;
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    chk("stall_hold", 64'(out_data), 64'h01);
    out_ready = 1'b1;
    wait_idle("p_stall");
    expect_pass("p_stall", 40'h01_01_A5_01_01);
    begin_pass();
    wait_idle("p_3c");
    expect_pass("p_3c", 40'h01_3C_A5_01_01);

    // write ch1 on the very edge ch1 is loaded
    begin_pass();
    wr_en = 1'b1; wr_ch = 3'd1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    wait_idle("p_fwd");
    expect_pass("p_fwd", 40'h01_77_A5_01_01);

    // out-of-range writes change nothing
    wr_en = 1'b1; wr_ch = 3'd5; wr_data = 8'hFF;
    tick();
    wr_ch = 3'd7; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    begin_pass();
    wait_idle("p_oor");
    expect_pass("p_oor", 40'h01_77_A5_01_01);

    // reset during the ch2 beat aborts and restores INIT_VAL
    begin_pass();
    wait_ch("rst_mid", 3'd2);
    collect = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rstmid_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    begin_pass();
    chk("rstmid_ch0", 64'(out_ch), 64'd0);
    wait_ch("fin_start", 3'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_last", {63'd0, out_valid}, 64'd0);
    tick();
    chk("start_on_last2", {63'd0, out_valid}, 64'd0);
    expect_pass("p_rst", 40'h01_01_01_01_01);

`ifdef PKG_VALUE_STREAMER_PARITY_EN
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'h07;
    tick();
    wr_en = 1'b0;
    begin_pass();
    chk("par_07", {63'd0, out_parity}, 64'd1);
    wait_idle("par_07");
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'h03;
    tick();
    wr_en = 1'b0;
    begin_pass();
    chk("par_03", {63'd0, out_parity}, 64'd0);
    wait_idle("par_03");
    collect = 1'b0;
`endif

    // randomized traffic; the model compare covers every cycle
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_ch     = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      start     = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1; wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    wait_idle("rand_drain");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
